// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: drives the decoder select pair from a small code FIFO, holding each code for DWELL cycles
// and free-running a 00..11 scan whenever the FIFO is empty and scanning is enabled.
module dec_sel_sequencer #(
    parameter int DWELL = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_code,
    input  logic                     scan_en,
    output logic                     a,
    output logic                     b,
    output logic                     active,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LOAD = CW'(DWELL - 1);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t        r_state;
    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_scan_ptr;
    logic          r_armed, r_a, r_b, r_active;
    logic          w_push, w_pick, w_pop, w_scan;
    assign in_ready   = r_count < (AW+1)'(DEPTH);
    assign w_push     = in_valid && in_ready;
    // r_armed holds off selection for the first edge after reset release
    assign w_pick     = r_armed && (r_state == IDLE || r_cnt == '0);
    assign w_pop      = w_pick && r_count != '0;
    assign w_scan     = w_pick && r_count == '0 && scan_en;
    assign a          = r_a;
    assign b          = r_b;
    assign active     = r_active;
    assign fifo_count = r_count;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_code;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cnt      <= '0;
            r_scan_ptr <= 2'b00;
            r_armed    <= 1'b0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_scan) r_scan_ptr <= r_scan_ptr + 2'd1;
            if (w_pop || w_scan) begin
                {r_a, r_b} <= w_pop ? r_mem[r_rd_ptr] : r_scan_ptr;
                r_cnt      <= LOAD;
                r_state    <= HOLD;
                r_active   <= 1'b1;
            end else if (w_pick) begin
                r_state  <= IDLE;
                r_active <= 1'b0;
            end else if (r_state == HOLD) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dec_sel_sequencer.sv
// tb_dec_sel_sequencer: directed vector table plus hand-written scan/priority/reset sequences
module tb_dec_sel_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_code = 2'b00;
    logic       scan_en = 1'b0;
    logic       a, b, active;
    logic [2:0] fifo_count;
    int         n_chk = 0;
    int         n_fail = 0;

    dec_sel_sequencer #(.DWELL(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .scan_en(scan_en), .a(a), .b(b), .active(active), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] code;
        int         n;
        logic [1:0] ab;
        logic       act;
        logic       rdy;
        logic [2:0] cnt;
    } vec_t;
    vec_t vecs [24];

    task automatic chk(input string nm, input logic [1:0] ab, input logic act, input logic rdy, input logic [2:0] cnt);
        n_chk++;
        if ({a, b, active, in_ready, fifo_count} !== {ab, act, rdy, cnt}) begin
            n_fail++;
            $display("FAIL %s @%0t: got a/b=%b%b active=%b ready=%b count=%0d, want a/b=%b active=%b ready=%b count=%0d",
                     nm, $time, a, b, active, in_ready, fifo_count, ab, act, rdy, cnt);
        end
    endtask

    task automatic run(input int n, input string nm, input logic [1:0] ab, input logic act, input logic [2:0] cnt);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk(nm, ab, act, cnt < 3'd4, cnt);
        end
    endtask

    initial begin
        // v, code, n, ab, act, rdy, cnt
        vecs[0]  = '{1'b1, 2'b10, 1, 2'b00, 1'b0, 1'b1, 3'd1};
        vecs[1]  = '{1'b0, 2'b00, 1, 2'b10, 1'b1, 1'b1, 3'd0};
        vecs[2]  = '{1'b0, 2'b00, 3, 2'b10, 1'b1, 1'b1, 3'd0};
        vecs[3]  = '{1'b0, 2'b00, 2, 2'b10, 1'b0, 1'b1, 3'd0};
        vecs[4]  = '{1'b1, 2'b01, 1, 2'b10, 1'b0, 1'b1, 3'd1};
        vecs[5]  = '{1'b1, 2'b11, 1, 2'b01, 1'b1, 1'b1, 3'd1};
        vecs[6]  = '{1'b1, 2'b00, 1, 2'b01, 1'b1, 1'b1, 3'd2};
        vecs[7]  = '{1'b0, 2'b00, 2, 2'b01, 1'b1, 1'b1, 3'd2};
        vecs[8]  = '{1'b0, 2'b00, 4, 2'b11, 1'b1, 1'b1, 3'd1};
        vecs[9]  = '{1'b0, 2'b00, 4, 2'b00, 1'b1, 1'b1, 3'd0};
        vecs[10] = '{1'b0, 2'b00, 1, 2'b00, 1'b0, 1'b1, 3'd0};
        vecs[11] = '{1'b1, 2'b11, 1, 2'b00, 1'b0, 1'b1, 3'd1};
        vecs[12] = '{1'b1, 2'b01, 1, 2'b11, 1'b1, 1'b1, 3'd1};
        vecs[13] = '{1'b1, 2'b10, 1, 2'b11, 1'b1, 1'b1, 3'd2};
        vecs[14] = '{1'b1, 2'b11, 1, 2'b11, 1'b1, 1'b1, 3'd3};
        vecs[15] = '{1'b1, 2'b01, 1, 2'b11, 1'b1, 1'b0, 3'd4};
        vecs[16] = '{1'b1, 2'b10, 1, 2'b01, 1'b1, 1'b1, 3'd3};
        vecs[17] = '{1'b1, 2'b10, 1, 2'b01, 1'b1, 1'b0, 3'd4};
        vecs[18] = '{1'b0, 2'b00, 2, 2'b01, 1'b1, 1'b0, 3'd4};
        vecs[19] = '{1'b0, 2'b00, 4, 2'b10, 1'b1, 1'b1, 3'd3};
        vecs[20] = '{1'b0, 2'b00, 4, 2'b11, 1'b1, 1'b1, 3'd2};
        vecs[21] = '{1'b0, 2'b00, 4, 2'b01, 1'b1, 1'b1, 3'd1};
        vecs[22] = '{1'b0, 2'b00, 4, 2'b10, 1'b1, 1'b1, 3'd0};
        vecs[23] = '{1'b0, 2'b00, 1, 2'b10, 1'b0, 1'b1, 3'd0};

        #2;
        chk("reset_initial", 2'b00, 1'b0, 1'b1, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single push, back-to-back pushes, full FIFO with a stalled push
        for (int i = 0; i < 24; i++) begin
            in_valid = vecs[i].v;
            in_code  = vecs[i].code;
            for (int k = 0; k < vecs[i].n; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d_c%0d", i, k), vecs[i].ab, vecs[i].act, vecs[i].rdy, vecs[i].cnt);
            end
        end
        in_valid = 1'b0;

        scan_en = 1'b1;
        run(4, "scan00", 2'b00, 1'b1, 3'd0);
        run(4, "scan01", 2'b01, 1'b1, 3'd0);
        run(4, "scan10", 2'b10, 1'b1, 3'd0);
        run(4, "scan11", 2'b11, 1'b1, 3'd0);
        run(4, "scan_wrap00", 2'b00, 1'b1, 3'd0);

        run(1, "prio_scan01", 2'b01, 1'b1, 3'd0);
        in_valid = 1'b1;
        in_code  = 2'b11;
        run(1, "prio_push", 2'b01, 1'b1, 3'd1);
        in_valid = 1'b0;
        run(2, "prio_no_cut", 2'b01, 1'b1, 3'd1);
        run(4, "prio_11", 2'b11, 1'b1, 3'd0);
        run(1, "prio_resume10", 2'b10, 1'b1, 3'd0);
        in_valid = 1'b1;
        run(1, "push2_in_10", 2'b10, 1'b1, 3'd1);
        in_valid = 1'b0;
        run(2, "hold10", 2'b10, 1'b1, 3'd1);
        run(1, "load11_again", 2'b11, 1'b1, 3'd0);
        in_valid = 1'b1;
        in_code  = 2'b01;
        run(1, "push_before_rst", 2'b11, 1'b1, 3'd1);
        in_valid = 1'b0;

        #3;
        rst = 1'b1;
        #1;
        chk("reset_async_midhold", 2'b00, 1'b0, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        chk("reset_held", 2'b00, 1'b0, 1'b1, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        run(1, "post_rst_edge1", 2'b00, 1'b0, 3'd0);
        run(4, "restart00", 2'b00, 1'b1, 3'd0);
        run(4, "restart01", 2'b01, 1'b1, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
